md_unit: RTL and testbench
==========================

# md_unit

Execute-stage multiply/divide unit for the pipelined MIPS core. Sits directly downstream of the E-stage forwarding multiplexers and consumes their forwarded rs/rt operands (MFRSE, MFRTE). It runs multi-cycle signed and unsigned multiply and divide into the HI/LO registers, and performs single-cycle mthi/mtlo writes. It exports Busy so the hazard unit can stall later HI/LO instructions in D.

## Interface
- WIDTH, 32: operand and HI/LO width.
- MULT_CYCLES, 5: Busy duration for mult/multu.
- DIV_CYCLES, 10: Busy duration for div/divu.

- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- MD_start  in  1  launch the operation in MD_op this cycle; one-cycle pulse from E-stage decode.
- MD_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6 and 7 are no-op.
- MFRSE  in  WIDTH  forwarded rs value (dividend / multiplicand / mthi-mtlo source).
- MFRTE  in  WIDTH  forwarded rt value (divisor / multiplier).
- Busy  out  1  an operation is in flight.
- HI  out  WIDTH  HI register; mfhi reads it combinationally in E.
- LO  out  WIDTH  LO register; mflo reads it combinationally in E.

## Operation
- Reset: HI=0, LO=0, Busy=0, counter=0, pending result cleared. An asserted reset_n low aborts any in-flight operation, and no HI/LO update follows.
- States: IDLE and RUN.
  - IDLE → RUN: MD_start=1 with MD_op in 0..3. On that edge, latch the full 2×WIDTH result into a pending register, computed from the MFRSE/MFRTE values of that cycle. Load the counter with MULT_CYCLES or DIV_CYCLES.
  - RUN: Busy=1 and the counter decrements each edge. On the edge where the counter reaches 0, copy the pending result into HI/LO and return to IDLE.
  - mthi/mtlo (MD_op 4/5) in IDLE: write MFRSE to HI/LO on that edge. There is no RUN state and Busy stays 0.
  - MD_op 6/7: ignored.
- MD_start is ignored while Busy=1, and HI/LO are untouched by it. The hazard unit guarantees that no start arrives in this case, but the block does not rely on that.
- Arithmetic:
  - mult: HI:LO = signed 64-bit product.
  - multu: HI:LO = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (either form): Busy still runs DIV_CYCLES, and HI/LO keep their previous values.
- HI/LO change only on the Busy-falling edge, on an mthi/mtlo edge, or on reset.

## Timing
- MD_start sampled at edge T0 → Busy high from after T0 through edge T0+N, where N = MULT_CYCLES or DIV_CYCLES. Busy is therefore exactly N cycles wide.
- New HI/LO are visible in the cycle after edge T0+N, the same cycle in which Busy is first 0.
- A new MD_start is accepted in the first cycle with Busy=0, so back-to-back operations have zero idle cycles.
- mthi/mtlo: new value is visible in the cycle after the start edge.
- Busy and HI/LO are registered outputs with no combinational path from the inputs.
- Stall contract (hazard unit side): stall D when (MD_start | Busy) and the D instruction is any mult/div/mfhi/mflo/mthi/mtlo.

## Structure
- Shared package md_pkg:
  - MD_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
  - Default latency constants.
  - State enum IDLE/RUN.
- One natural sub-module, md_calc: purely combinational. Takes op, a and b; returns {hi, lo} and a div_by_zero flag. It isolates signedness and divide-by-zero handling from the control FSM.
- The top level holds the FSM, the counter, the pending register and HI/LO.

## Test plan
- Reset mid-mult: start mult 3×4, then pull reset_n low at cycle 2 → HI=0, LO=0, Busy=0 immediately. No later HI/LO update occurs.
- mult 0xFFFFFFFF × 2 → Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. The same operands with multu give HI=0x00000001, LO=0xFFFFFFFE.
- div −7 / 2 → Busy high 10 cycles, then LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). The same operands with divu give LO=0x7FFFFFFC, HI=1.
- divu 5 / 0 with prior HI=0x11, LO=0x22 → Busy high 10 cycles, HI/LO remain 0x11/0x22. div 0x80000000 / −1 gives LO=0x80000000, HI=0.
- MD_start (mult 2×2) pulsed during a running div → ignored. Only the div result appears, and Busy falls after the original 10 cycles.
- mtlo 0xDEAD then mult 3×5 issued on the next cycle (back-to-back) → LO=0xDEAD one cycle after the first start. After 5 Busy cycles, HI=0 and LO=15.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// operation encodings, default latencies and the control state type.
package md_pkg;

    localparam int MD_OP_W            = 3;
    localparam int MD_DEF_WIDTH       = 32;
    localparam int MD_DEF_MULT_CYCLES = 5;
    localparam int MD_DEF_DIV_CYCLES  = 10;

    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_NOP6  = 3'd6,
        MD_NOP7  = 3'd7
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // Multi-cycle operations go through RUN; mthi/mtlo and the no-ops do not.
    function automatic logic is_long_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_if.sv
// Operand/result bundle between the E-stage forwarding muxes and md_unit.
// The master side is the E-stage decode; the slave side is md_unit.
interface md_if
    import md_pkg::*;
#(
    parameter int WIDTH = MD_DEF_WIDTH
);

    logic               MD_start;
    logic [MD_OP_W-1:0] MD_op;
    logic [WIDTH-1:0]   MFRSE;
    logic [WIDTH-1:0]   MFRTE;
    logic               Busy;
    logic [WIDTH-1:0]   HI;
    logic [WIDTH-1:0]   LO;

    modport master (
        output MD_start, MD_op, MFRSE, MFRTE,
        input  Busy, HI, LO
    );

    modport slave (
        input  MD_start, MD_op, MFRSE, MFRTE,
        output Busy, HI, LO
    );

endinterface

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath. Produces the full {hi, lo} result
// for one operation and flags a zero divisor for the divide forms.
module md_calc
    import md_pkg::*;
#(
    parameter int WIDTH = MD_DEF_WIDTH
) (
    input  md_op_e             op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   b_safe;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;

    // NOTE: every signal assigned here gets a default first, so no path
    // through the block leaves a value held and no latch is inferred.
    always_comb begin
        result      = '0;
        div_by_zero = 1'b0;
        signed_op   = (op == MD_MULT) || (op == MD_DIV);
        a_neg       = signed_op && a[WIDTH-1];
        b_neg       = signed_op && b[WIDTH-1];

        // Signed multiply: the low 2W bits of the product of sign-extended
        // operands equal the true signed product.
        a_ext = signed_op ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext = signed_op ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};

        // Signed divide works on magnitudes; MIN / -1 falls out naturally as
        // an unsigned 0x80.. quotient that negates back to itself.
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        b_safe = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem    = a_neg ? -r_mag : r_mag;

        case (op)
            MD_MULT, MD_MULTU: result = a_ext * b_ext;
            MD_DIV, MD_DIVU: begin
                div_by_zero = (b == '0);
                result      = {rem, quot};
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit: a two-state FSM holding the latency
// counter, the pending result and the architectural HI/LO registers.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = MD_DEF_WIDTH,
    parameter int MULT_CYCLES = MD_DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DEF_DIV_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    md_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] pending;
    logic               pending_wr;
    logic               busy_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    md_op_e             op;
    logic [2*WIDTH-1:0] calc_result;
    logic               calc_dbz;

    assign op = md_op_e'(bus.MD_op);

    md_calc #(
        .WIDTH(WIDTH)
    ) u_calc (
        .op          (op),
        .a           (bus.MFRSE),
        .b           (bus.MFRTE),
        .result      (calc_result),
        .div_by_zero (calc_dbz)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            busy_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            // NOTE: the pending result is reset too; together with
            // pending_wr this guarantees an aborted operation never lands.
            pending    <= '0;
            pending_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.MD_start) begin
                        if (is_long_op(op)) begin
                            pending    <= calc_result;
                            pending_wr <= !calc_dbz;
                            cnt        <= is_div_op(op) ? CNT_W'(DIV_CYCLES)
                                                        : CNT_W'(MULT_CYCLES);
                            busy_q     <= 1'b1;
                            state      <= RUN;
                        end else if (op == MD_MTHI) begin
                            hi_q <= bus.MFRSE;
                        end else if (op == MD_MTLO) begin
                            lo_q <= bus.MFRSE;
                        end
                    end
                end
                RUN: begin
                    // Starts are deliberately not looked at here.
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        if (pending_wr) begin
                            {hi_q, lo_q} <= pending;
                        end
                        pending_wr <= 1'b0;
                        busy_q     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Busy = busy_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected {HI,LO} and Busy widths are queued
// when an operation is launched and compared when Busy falls.
module tb_md_unit;
    import md_pkg::*;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    int unsigned cyc     = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [63:0] exp_q[$];
    int          cyc_q[$];
    logic [31:0] sh_hi = '0;
    logic [31:0] sh_lo = '0;

    md_if #(.WIDTH(W)) bus ();

    md_unit #(
        .WIDTH       (W),
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // Independent reference model built on 64-bit host arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] prev);
        longint sa, sb;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        model = prev;
        case (op)
            3'd0: model = 64'(sa * sb);
            3'd1: model = {32'b0, a} * {32'b0, b};
            3'd2: if (b != 0) begin
                q = 32'(sa / sb);
                r = 32'(sa % sb);
                model = {r, q};
            end
            3'd3: if (b != 0) model = {a % b, a / b};
            default: model = prev;
        endcase
    endfunction

    // Called at "#1 after an edge"; returns at the same phase after the start edge.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.MD_start = 1'b1;
        bus.MD_op    = op;
        bus.MFRSE    = a;
        bus.MFRTE    = b;
        @(posedge clk);
        #1;
        bus.MD_start = 1'b0;
        bus.MD_op    = 3'd7;
    endtask

    task automatic wait_idle(input int unsigned t0, output int width);
        int guard = 0;
        while (bus.Busy === 1'b1 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        width = int'(cyc - t0);
    endtask

    task automatic run_long(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] expv, output int width);
        int unsigned t0;
        exp_q.push_back(expv);
        cyc_q.push_back((op >= 3'd2) ? DC : MC);
        start_op(op, a, b);
        t0 = cyc;
        wait_idle(t0, width);
    endtask

    task automatic test_reset();
        bus.MD_start = 1'b0;
        bus.MD_op    = 3'd7;
        bus.MFRSE    = '0;
        bus.MFRTE    = '0;
        reset_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.HI !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected %h", bus.HI, 32'h0); end
        n_checks++; if (bus.LO !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected %h", bus.LO, 32'h0); end
        n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_mult();
        start_op(3'd4, 32'h55, 32'h0);
        n_checks++; if (bus.HI !== 32'h55) begin n_fail++; $display("FAIL mthi_pre_reset: got %h expected %h", bus.HI, 32'h55); end
        start_op(3'd0, 32'd3, 32'd4);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.HI !== 32'h0) begin n_fail++; $display("FAIL abort_hi: got %h expected %h", bus.HI, 32'h0); end
        n_checks++; if (bus.LO !== 32'h0) begin n_fail++; $display("FAIL abort_lo: got %h expected %h", bus.LO, 32'h0); end
        n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.Busy); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_checks++; if ({bus.HI, bus.LO} !== 64'h0) begin n_fail++; $display("FAIL abort_no_update: got %h expected %h", {bus.HI, bus.LO}, 64'h0); end
        n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_after: got %b expected 0", bus.Busy); end
        sh_hi = '0;
        sh_lo = '0;
    endtask

    task automatic test_mult();
        logic [2:0]  ops [2] = '{3'd0, 3'd1};
        logic [63:0] exps[2] = '{64'hFFFFFFFF_FFFFFFFE, 64'h00000001_FFFFFFFE};
        int width;
        logic [63:0] e;
        int ec;
        for (int i = 0; i < 2; i++) begin
            run_long(ops[i], 32'hFFFFFFFF, 32'd2, exps[i], width);
            e  = exp_q.pop_front();
            ec = cyc_q.pop_front();
            n_checks++; if (width !== ec) begin n_fail++; $display("FAIL mult%0d_busy_width: got %0d expected %0d", i, width, ec); end
            n_checks++; if ({bus.HI, bus.LO} !== e) begin n_fail++; $display("FAIL mult%0d_hilo: got %h expected %h", i, {bus.HI, bus.LO}, e); end
            {sh_hi, sh_lo} = e;
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [3] = '{3'd2, 3'd3, 3'd2};
        logic [31:0] as  [3] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000};
        logic [31:0] bs  [3] = '{32'd2, 32'd2, 32'hFFFFFFFF};
        logic [63:0] exps[3] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_7FFFFFFC, 64'h00000000_80000000};
        int width;
        logic [63:0] e;
        int ec;
        for (int i = 0; i < 3; i++) begin
            run_long(ops[i], as[i], bs[i], exps[i], width);
            e  = exp_q.pop_front();
            ec = cyc_q.pop_front();
            n_checks++; if (width !== ec) begin n_fail++; $display("FAIL div%0d_busy_width: got %0d expected %0d", i, width, ec); end
            n_checks++; if ({bus.HI, bus.LO} !== e) begin n_fail++; $display("FAIL div%0d_hilo: got %h expected %h", i, {bus.HI, bus.LO}, e); end
            {sh_hi, sh_lo} = e;
        end
    endtask

    task automatic test_div_by_zero();
        int width;
        logic [63:0] e;
        int ec;
        start_op(3'd4, 32'h11, 32'h0);
        start_op(3'd5, 32'h22, 32'h0);
        for (int i = 0; i < 2; i++) begin
            run_long((i == 0) ? 3'd3 : 3'd2, 32'd5, 32'd0, 64'h00000011_00000022, width);
            e  = exp_q.pop_front();
            ec = cyc_q.pop_front();
            n_checks++; if (width !== ec) begin n_fail++; $display("FAIL dbz%0d_busy_width: got %0d expected %0d", i, width, ec); end
            n_checks++; if ({bus.HI, bus.LO} !== e) begin n_fail++; $display("FAIL dbz%0d_hilo: got %h expected %h", i, {bus.HI, bus.LO}, e); end
        end
        sh_hi = 32'h11;
        sh_lo = 32'h22;
    endtask

    task automatic test_ignored_start();
        int unsigned t0;
        int width;
        logic [63:0] e;
        int ec;
        exp_q.push_back({32'd2, 32'd14});
        cyc_q.push_back(DC);
        start_op(3'd2, 32'd100, 32'd7);
        t0 = cyc;
        repeat (2) begin @(posedge clk); #1; end
        start_op(3'd0, 32'd2, 32'd2);
        n_checks++; if ({bus.HI, bus.LO} !== {sh_hi, sh_lo}) begin n_fail++; $display("FAIL ignored_hilo_untouched: got %h expected %h", {bus.HI, bus.LO}, {sh_hi, sh_lo}); end
        wait_idle(t0, width);
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        n_checks++; if (width !== ec) begin n_fail++; $display("FAIL ignored_busy_width: got %0d expected %0d", width, ec); end
        n_checks++; if ({bus.HI, bus.LO} !== e) begin n_fail++; $display("FAIL ignored_hilo: got %h expected %h", {bus.HI, bus.LO}, e); end
        // A second operation would have kept Busy high.
        @(posedge clk);
        #1;
        n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL ignored_no_restart: got %b expected 0", bus.Busy); end
        {sh_hi, sh_lo} = e;
    endtask

    task automatic test_back_to_back();
        int width;
        logic [63:0] e;
        int ec;
        start_op(3'd5, 32'hDEAD, 32'h0);
        n_checks++; if (bus.LO !== 32'hDEAD) begin n_fail++; $display("FAIL mtlo_value: got %h expected %h", bus.LO, 32'hDEAD); end
        n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy: got %b expected 0", bus.Busy); end
        run_long(3'd0, 32'd3, 32'd5, {32'd0, 32'd15}, width);
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        n_checks++; if (width !== ec) begin n_fail++; $display("FAIL b2b_busy_width: got %0d expected %0d", width, ec); end
        n_checks++; if ({bus.HI, bus.LO} !== e) begin n_fail++; $display("FAIL b2b_hilo: got %h expected %h", {bus.HI, bus.LO}, e); end
        {sh_hi, sh_lo} = e;
    endtask

    task automatic test_random();
        int width;
        logic [63:0] e;
        int ec;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            run_long(op, a, b, model(op, a, b, {sh_hi, sh_lo}), width);
            e  = exp_q.pop_front();
            ec = cyc_q.pop_front();
            n_checks++; if (width !== ec) begin n_fail++; $display("FAIL rnd%0d_busy_width: op %0d got %0d expected %0d", i, op, width, ec); end
            n_checks++; if ({bus.HI, bus.LO} !== e) begin n_fail++; $display("FAIL rnd%0d_hilo: op %0d a %h b %h got %h expected %h", i, op, a, b, {bus.HI, bus.LO}, e); end
            {sh_hi, sh_lo} = e;
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_mult();
        test_mult();
        test_div();
        test_div_by_zero();
        test_ignored_start();
        test_back_to_back();
        test_random();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
